barrel_shifter_pipe: RTL and testbench
======================================

Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter/rotator with valid/ready handshake on both sides.
- Generalises the team's fixed 16-bit combinational shifters to any power-of-two width.
- Adds five shift modes, one register per log2 stage, and backpressure.
- Sits between register-file read and ALU writeback in the lab datapath; accepts one operation per cycle.

Parameters:
- WIDTH, 16, data width; power of two, minimum 4.
- AMT_W, $clog2(WIDTH), derived localparam: shift-amount width and pipeline depth. Not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept the operation this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift/rotate amount, 0..WIDTH-1.
- in_mode  in  3  operation select; encoding in Behaviour.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  result.

Behaviour:
- Mode encoding:
  - 000 SLL: logical left, zero fill.
  - 001 SRL: logical right, zero fill.
  - 010 SRA: arithmetic right, sign fill.
  - 011 ROL: rotate left.
  - 100 ROR: rotate right.
  - 101..111: pass-through, out_data = in_data.
- amt = 0 in any mode: result equals operand.
- Pipeline:
  - AMT_W registered stages; stage k shifts by 2^k when amt bit k = 1.
  - Each stage carries valid, data, the remaining amt bits and mode.
- Latency: an operation accepted on edge N gives out_valid = 1 after edge N+AMT_W (4 cycles at WIDTH=16). Throughput is 1 op/cycle when unstalled.
- Transfers:
  - Input transfer occurs on an edge where in_valid && in_ready.
  - Output transfer occurs on an edge where out_valid && out_ready.
- Stall (global, no bubble collapse):
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance = 0, every stage register holds and out_data/out_valid stay stable.
- Bubbles: if in_valid = 0 while advancing, a valid = 0 slot enters stage 0. Data registers of invalid slots are don't-care, but out_data must be 0 whenever out_valid = 0.
- Ordering: results leave in acceptance order, with no loss or duplication under any out_ready pattern.
- Reset:
  - Asserting reset clears all stage valid bits and data to 0 immediately (asynchronous), including mid-stream. In-flight operations are discarded.
  - Outputs during and after reset: out_valid = 0, out_data = 0, in_ready = 1 (follows from advance).
  - On the first edge after reset deasserts, a new operation is accepted normally.
- Simultaneous accept and emit on the same edge is legal and required at full throughput.
- Out-of-range in_mode never locks the pipe; it behaves as pass-through.

Optional Feature:
- Macro: SHIFTER_FLAGS_EN.
- When defined, two extra outputs are present, registered alongside out_data, both 0 when out_valid = 0 and on reset:
  - out_zero (1): result == 0.
  - out_cout (1): last bit shifted out. SLL uses a[WIDTH-amt], SRL/SRA use a[amt-1], ROL uses result[0], ROR uses result[WIDTH-1]. Value is 0 when amt = 0 or in pass-through.
- When undefined, these ports and their stage registers do not exist; all other behaviour is identical.

Decomposition:
- Package shifter_pkg holds:
  - shift_mode_t, a 3-bit typedef.
  - Mode constants MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR.
- Sub-module shifter_stage (parameters WIDTH, STEP):
  - Combinational shift by STEP or 0 for a given mode, plus cout propagation.
  - Instantiated AMT_W times in a generate loop; the top owns all registers and the handshake.

Test Plan:
- SLL in_data=16'h0001, amt=15, out_ready=1 -> out_data=16'h8000, out_valid exactly 4 cycles after accept.
- in_data=16'hF3FF, amt=4: SRA -> 16'hFF3F, SRL -> 16'h0F3F; back-to-back accepts give results on consecutive cycles.
- ROR 16'h0001 amt=1 -> 16'h8000; ROL 16'h8001 amt=4 -> 16'h0018; mode=3'b111 with 16'h1234 -> 16'h1234.
- Stream 6 ops, hold out_ready=0 for 3 cycles after first out_valid -> in_ready=0, out_data stable, all 6 results in order with no duplicates.
- Assert reset with 3 ops in flight -> out_valid=0 and out_data=0 immediately; nothing emerges after release; next op has normal latency.
- With SHIFTER_FLAGS_EN: SLL 16'h8000 amt=1 -> out_data=0, out_zero=1, out_cout=1; SRL 16'h0002 amt=1 -> out_cout=0, out_zero=0.

Source files
------------

// File: rtl/shifter_pkg.sv
// Mode encoding shared by the barrel shifter pipeline and its per-stage shift slices.
package shifter_pkg;

  typedef logic [2:0] shift_mode_t;

  localparam shift_mode_t MODE_SLL = 3'b000;
  localparam shift_mode_t MODE_SRL = 3'b001;
  localparam shift_mode_t MODE_SRA = 3'b010;
  localparam shift_mode_t MODE_ROL = 3'b011;
  localparam shift_mode_t MODE_ROR = 3'b100;

endpackage

// File: rtl/shifter_stage.sv
// One log2 slice: shifts/rotates by STEP when i_en is set, otherwise passes through; zero latency.
// No handshake here -- the top owns every register and the stall.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_en,
  input  shift_mode_t      i_mode,
  input  logic             i_cout,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_cout
);

  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;

  assign w_sra = $unsigned($signed(i_dat) >>> STEP);
  assign w_rol = (i_dat << STEP) | (i_dat >> (WIDTH - STEP));
  assign w_ror = (i_dat >> STEP) | (i_dat << (WIDTH - STEP));

  // The highest enabled slice is the last to overwrite o_cout, so the carry that
  // survives the chain is the bit dropped by the final partial shift.
  always_comb begin
    o_dat  = i_dat;
    o_cout = i_cout;
    if (i_en) begin
      case (i_mode)
        MODE_SLL: begin
          o_dat  = i_dat << STEP;
          o_cout = i_dat[WIDTH-STEP];
        end
        MODE_SRL: begin
          o_dat  = i_dat >> STEP;
          o_cout = i_dat[STEP-1];
        end
        MODE_SRA: begin
          o_dat  = w_sra;
          o_cout = i_dat[STEP-1];
        end
        MODE_ROL: begin
          o_dat  = w_rol;
          o_cout = w_rol[0];
        end
        MODE_ROR: begin
          o_dat  = w_ror;
          o_cout = w_ror[WIDTH-1];
        end
        default: begin
          o_dat  = i_dat;
          o_cout = i_cout;
        end
      endcase
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator: operand register + one register per log2 stage, result AMT_W edges after accept.
// Global stall: in_ready = !out_valid || out_ready; SHIFTER_FLAGS_EN adds registered out_zero/out_cout.
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_cout
`endif
);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("barrel_shifter_pipe: WIDTH must be a power of two, at least 4");
  end

  // Slot 0 holds the accepted operation; slot k+1 holds the result of slice k.
  logic [AMT_W:0]   r_vld;
  logic [WIDTH-1:0] r_dat  [0:AMT_W];
  logic [AMT_W-1:0] r_amt  [0:AMT_W-1];
  shift_mode_t      r_mode [0:AMT_W-1];

  logic [WIDTH-1:0] w_dat  [0:AMT_W-1];
  logic [AMT_W-1:0] w_cout;
  logic             w_advance;

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

`ifdef SHIFTER_FLAGS_EN
  logic r_cout [1:AMT_W];
  logic r_zero;
`endif

  // r_amt is shifted right each stage, so bit 0 is always the bit for the current slice.
  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    logic w_cin;
`ifdef SHIFTER_FLAGS_EN
    if (k == 0) begin : g_first
      assign w_cin = 1'b0;
    end else begin : g_rest
      assign w_cin = r_cout[k];
    end
`else
    assign w_cin = 1'b0;
`endif

    shifter_stage #(
      .WIDTH (WIDTH),
      .STEP  (1 << k)
    ) u_stage (
      .i_dat  (r_dat[k]),
      .i_en   (r_amt[k][0]),
      .i_mode (r_mode[k]),
      .i_cout (w_cin),
      .o_dat  (w_dat[k]),
      .o_cout (w_cout[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      for (int k = 0; k <= AMT_W; k++) begin
        r_dat[k] <= '0;
      end
      for (int k = 0; k < AMT_W; k++) begin
        r_amt[k]  <= '0;
        r_mode[k] <= MODE_SLL;
      end
    end else if (w_advance) begin
      r_vld     <= {r_vld[AMT_W-1:0], in_valid};
      r_dat[0]  <= in_data;
      r_amt[0]  <= in_amt;
      r_mode[0] <= in_mode;
      for (int k = 0; k < AMT_W; k++) begin
        r_dat[k+1] <= w_dat[k];
      end
      for (int k = 0; k < AMT_W - 1; k++) begin
        r_amt[k+1]  <= r_amt[k] >> 1;
        r_mode[k+1] <= r_mode[k];
      end
    end
  end

  // Bubble slots carry stale data, so the visible outputs are gated by valid.
  assign out_valid = r_vld[AMT_W];
  assign out_data  = out_valid ? r_dat[AMT_W] : '0;

`ifdef SHIFTER_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= AMT_W; k++) begin
        r_cout[k] <= 1'b0;
      end
      r_zero <= 1'b0;
    end else if (w_advance) begin
      for (int k = 1; k <= AMT_W; k++) begin
        r_cout[k] <= w_cout[k-1];
      end
      r_zero <= (w_dat[AMT_W-1] == '0);
    end
  end

  assign out_zero = out_valid & r_zero;
  assign out_cout = out_valid & r_cout[AMT_W];
`else
  logic w_cout_unused;
  assign w_cout_unused = ^w_cout;
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe at WIDTH=16: directed steps plus random traffic against a whole-amount reference model.
// Define SHIFTER_FLAGS_EN for both files to also check out_zero/out_cout.
module tb_barrel_shifter_pipe;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [AW-1:0] in_amt;
  logic [2:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
`ifdef SHIFTER_FLAGS_EN
  logic          out_zero;
  logic          out_cout;
  logic          got_z[$];
  logic          got_co[$];
`endif

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFTER_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_cout  (out_cout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         z;
    logic         c;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] got_d[$];
  int           got_c[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           last_lat = 0;
  logic         stalled_prev = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         last_in_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  // Whole-amount reference: shift once by n, rotates via a doubled word.
  function automatic exp_t model(input logic [W-1:0] a, input logic [AW-1:0] amt, input logic [2:0] m);
    exp_t        e;
    int          n;
    logic [31:0] dbl;
    logic [31:0] sx;
    logic [W-1:0] r;
    logic        c;
    n   = int'(amt);
    dbl = {a, a};
    sx  = {{16{a[W-1]}}, a};
    r   = a;
    c   = 1'b0;
    case (m)
      3'd0: begin r = a << n;  if (n != 0) c = a[W-n]; end
      3'd1: begin r = a >> n;  if (n != 0) c = a[n-1]; end
      3'd2: begin sx = sx >> n; r = sx[15:0]; if (n != 0) c = a[n-1]; end
      3'd3: begin dbl = dbl << n; r = dbl[31:16]; if (n != 0) c = r[0]; end
      3'd4: begin dbl = dbl >> n; r = dbl[15:0]; if (n != 0) c = r[W-1]; end
      default: begin r = a; c = 1'b0; end
    endcase
    e.d   = r;
    e.z   = (r == '0);
    e.c   = c;
    e.acc = 0;
    return e;
  endfunction

  // One cycle: drive at edge+1, sample at edge+2, then advance to the next edge+1.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [AW-1:0] a,
                      input logic [2:0] m, input logic ordy, output logic acc);
    exp_t e;
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_mode   = m;
    out_ready = ordy;
    #1;
    last_in_ready = in_ready;
    chk("in_ready_rule", in_ready, !out_valid || ordy);
    if (!out_valid) begin
      chk("idle_data_zero", out_data, 0);
`ifdef SHIFTER_FLAGS_EN
      chk("idle_zero_flag", out_zero, 0);
      chk("idle_cout_flag", out_cout, 0);
`endif
    end
    if (stalled_prev) begin
      chk("stall_valid_held", out_valid, 1);
      chk("stall_data_held", out_data, prev_data);
    end
    if (out_valid && ordy) begin
      chk("emit_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", out_data, e.d);
`ifdef SHIFTER_FLAGS_EN
        chk("result_zero", out_zero, e.z);
        chk("result_cout", out_cout, e.c);
        got_z.push_back(out_zero);
        got_co.push_back(out_cout);
`endif
        last_lat = cyc - e.acc;
        got_d.push_back(out_data);
        got_c.push_back(cyc);
      end
    end
    acc = v && in_ready;
    if (acc) begin
      e     = model(d, a, m);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    stalled_prev = out_valid && !ordy;
    prev_data    = out_data;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_logs();
    got_d.delete();
    got_c.delete();
`ifdef SHIFTER_FLAGS_EN
    got_z.delete();
    got_co.delete();
`endif
  endtask

  task automatic drain(input string tag);
    logic acc;
    int   n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      step(1'b0, '0, '0, 3'd0, 1'b1, acc);
      n++;
    end
    chk({"drain_", tag}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         acc;
    logic [W-1:0] rd;
    logic [W-1:0] sd [0:6];
    logic [AW-1:0] sa [0:6];
    logic [2:0]   sm [0:6];
    int           issued;
    int           stall_left;
    logic         ordy;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = 3'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // SLL by the maximum amount, with exact latency.
    clear_logs();
    step(1'b1, 16'h0001, 4'd15, 3'd0, 1'b1, acc);
    drain("sll15");
    chk("sll15_count", got_d.size(), 1);
    if (got_d.size() > 0) chk("sll15_data", got_d[0], 16'h8000);
    chk("sll15_latency", last_lat, 4);

    // SRA vs SRL back to back.
    clear_logs();
    step(1'b1, 16'hF3FF, 4'd4, 3'd2, 1'b1, acc);
    step(1'b1, 16'hF3FF, 4'd4, 3'd1, 1'b1, acc);
    drain("sra_srl");
    chk("sra_srl_count", got_d.size(), 2);
    if (got_d.size() > 1) begin
      chk("sra_data", got_d[0], 16'hFF3F);
      chk("srl_data", got_d[1], 16'h0F3F);
      chk("b2b_consecutive", got_c[1] - got_c[0], 1);
    end

    // Rotates and pass-through mode.
    clear_logs();
    step(1'b1, 16'h0001, 4'd1, 3'd4, 1'b1, acc);
    step(1'b1, 16'h8001, 4'd4, 3'd3, 1'b1, acc);
    step(1'b1, 16'h1234, 4'd5, 3'd7, 1'b1, acc);
    drain("rot");
    chk("rot_count", got_d.size(), 3);
    if (got_d.size() > 2) begin
      chk("ror_data", got_d[0], 16'h8000);
      chk("rol_data", got_d[1], 16'h0018);
      chk("pass_data", got_d[2], 16'h1234);
    end

    // amt = 0 leaves the operand untouched in every mode.
    clear_logs();
    for (int m = 0; m < 8; m++) step(1'b1, 16'hA5C3, 4'd0, 3'(m), 1'b1, acc);
    drain("amt0");
    chk("amt0_count", got_d.size(), 8);
    for (int i = 0; i < got_d.size(); i++) chk("amt0_data", got_d[i], 16'hA5C3);

    // Six ops with a 3-cycle downstream stall after the first result.
    clear_logs();
    for (int i = 0; i < 7; i++) begin
      sd[i] = W'($urandom);
      sa[i] = AW'($urandom_range(0, 15));
      sm[i] = 3'($urandom_range(0, 4));
    end
    issued     = 0;
    stall_left = 3;
    for (int i = 0; i < 60 && (issued < 6 || exp_q.size() != 0); i++) begin
      ordy = 1'b1;
      if (out_valid && stall_left > 0) begin
        ordy = 1'b0;
        stall_left--;
      end
      step(issued < 6, sd[issued], sa[issued], sm[issued], ordy, acc);
      if (!ordy) chk("stall_in_ready", last_in_ready, 0);
      if (acc) issued++;
    end
    drain("stall");
    chk("stall_applied", stall_left, 0);
    chk("stall_count", got_d.size(), 6);

    // Random traffic with random bubbles and backpressure.
    clear_logs();
    issued = 0;
    for (int i = 0; i < 3000 && issued < 300; i++) begin
      rd = W'($urandom);
      step($urandom_range(0, 3) != 0, rd, AW'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7, acc);
      if (acc) issued++;
    end
    drain("random");
    chk("random_count", got_d.size(), 300);

    // Reset with operations in flight: everything is discarded.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      rd = W'($urandom);
      step(1'b1, rd, 4'd3, 3'd1, 1'b1, acc);
    end
    step(1'b0, '0, '0, 3'd0, 1'b1, acc);
    chk("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    stalled_prev = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 3'd0, 1'b1, acc);
    chk("post_reset_silent", got_d.size(), 0);
    step(1'b1, 16'h00F0, 4'd4, 3'd1, 1'b1, acc);
    chk("post_reset_accept", acc, 1);
    drain("post_reset");
    chk("post_reset_count", got_d.size(), 1);
    if (got_d.size() > 0) chk("post_reset_data", got_d[0], 16'h000F);
    chk("post_reset_latency", last_lat, 4);

`ifdef SHIFTER_FLAGS_EN
    clear_logs();
    step(1'b1, 16'h8000, 4'd1, 3'd0, 1'b1, acc);
    step(1'b1, 16'h0002, 4'd1, 3'd1, 1'b1, acc);
    drain("flags");
    chk("flags_count", got_d.size(), 2);
    if (got_d.size() > 1) begin
      chk("flag_sll_data", got_d[0], 16'h0000);
      chk("flag_sll_zero", got_z[0], 1);
      chk("flag_sll_cout", got_co[0], 1);
      chk("flag_srl_data", got_d[1], 16'h0001);
      chk("flag_srl_zero", got_z[1], 0);
      chk("flag_srl_cout", got_co[1], 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
